fifo_serializer: RTL and testbench
==================================

Name: fifo_serializer

Overview:
Downstream read-side consumer of the 4-bit synchronous FIFO. Whenever the FIFO is non-empty and transmission is enabled, it pops one word and shifts it out on a single-wire serial line as a frame: start bit, data LSB first, stop bit. It owns the FIFO rd_en, so the FIFO drains at line rate without external control.

Parameters:
DATA_W, 4, word width; must match FIFO data width.
CLK_DIV, 4, clk cycles per serial bit; legal range is 1 or greater.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
tx_en  input  1  enables starting new frames; sampled in IDLE and at end of STOP.
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after fifo_rd_en.
fifo_empty  input  1  FIFO mem_empty.
fifo_rd_en  output  1  FIFO read strobe; one-cycle pulse per word.
ser_out  output  1  serial line; idles high.
busy  output  1  high from POP through the last STOP cycle.
frame_done  output  1  one-cycle pulse in the final cycle of STOP.

Behaviour:
- Reset (rst=0, async): ser_out=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, all counters=0. Takes effect immediately, including mid-frame; the partially sent word is lost and is not re-read.
- All outputs are registered.
- States: IDLE, POP, LOAD, START, DATA, STOP. PARITY is added only with the optional feature.
- IDLE: ser_out=1. Go to POP when tx_en=1 and fifo_empty=0; otherwise stay.
- POP (1 cycle): fifo_rd_en=1, busy=1. Go to LOAD.
- LOAD (1 cycle): capture fifo_data into shift register. Go to START.
- START: ser_out=0 for CLK_DIV cycles.
- DATA: ser_out=shift[0] for CLK_DIV cycles per bit. Shift right after each bit. Bit index runs 0..DATA_W-1, then go to STOP.
- STOP: ser_out=1 for CLK_DIV cycles. frame_done=1 in the last cycle.
- After STOP: if tx_en=1 and fifo_empty=0, go directly to POP with no IDLE cycle; otherwise go to IDLE.
- Frame length is (DATA_W+2)*CLK_DIV cycles. Back-to-back frames are separated by exactly 2 cycles (POP, LOAD) with ser_out=1.
- Baud counter is $clog2(CLK_DIV)+1 bits wide and counts 0..CLK_DIV-1. It wraps to 0 at each bit boundary. With CLK_DIV=1 each bit lasts one cycle.
- fifo_rd_en is never asserted while fifo_empty=1, and never more than once per frame.
- tx_en falling mid-frame: the current frame completes fully, then the block goes to IDLE.
- fifo_empty rising during a frame has no effect on that frame.

Optional Feature:
Macro FIFO_SER_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It lasts CLK_DIV cycles with ser_out = XOR of the DATA_W data bits (even parity). Frame length becomes (DATA_W+3)*CLK_DIV.
- Undefined: no PARITY state and no parity logic; the frame is as above.

Test Plan:
- CLK_DIV=4, FIFO holds 4'b0011, tx_en=1. Required: one fifo_rd_en pulse, then ser_out = 0,1,1,0,0,1, each for 4 cycles (24 cycles total). frame_done pulses once, busy falls, ser_out stays 1.
- FIFO empty, tx_en=1 for 100 cycles. Required: fifo_rd_en never asserted, ser_out=1, busy=0.
- Fill FIFO with 16 words (0000, 0011, 0110, 1000, 0010, 0100, 1010, 0111, 1011, 0110, 1000, 0010, 0100, 1010, 0111, 1011), then tx_en=1. Required: 16 rd_en pulses and 16 frame_done pulses, decoded words in order, 2-cycle gaps between frames, busy falls when mem_empty=1.
- Drop tx_en during DATA of frame 1 with words still queued. Required: frame 1 completes with correct stop bit, no further rd_en, state IDLE.
- Assert rst=0 asynchronously mid-DATA. Required: ser_out=1 and busy=0 before the next clk edge. After release with FIFO non-empty and tx_en=1, the next frame starts with a fresh POP.
- With FIFO_SER_PARITY_EN defined, CLK_DIV=1, send 4'b0111. Required: ser_out = 0,1,1,1,0,1,1 (parity bit = 1); frame_done in cycle 7 of the frame.

Source files
------------

// File: rtl/fifo_serializer.sv
// Pops words from a synchronous FIFO and sends each as a serial frame: start, data LSB first, stop.
// Define FIFO_SER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_serializer #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_en_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  output logic              ser_out_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BitW = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

`ifdef FIFO_SER_PARITY_EN
  typedef enum logic [2:0] {
    StIdle, StPop, StLoad, StStart, StData, StParity, StStop
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StPop, StLoad, StStart, StData, StStop
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_q, ser_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              start_ok;
`ifdef FIFO_SER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_end  = (cnt_q == CntLast);
  assign start_ok = tx_en_i & ~fifo_empty_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef FIFO_SER_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StPop;
      end
      StPop: state_d = StLoad;
      StLoad: begin
        // FIFO data is valid the cycle after the read strobe.
        shift_d  = fifo_data_i;
`ifdef FIFO_SER_PARITY_EN
        parity_d = ^fifo_data_i;
`endif
        cnt_d    = '0;
        state_d  = StStart;
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
`ifdef FIFO_SER_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef FIFO_SER_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          // Chain straight into the next frame when more data is waiting.
          cnt_d   = '0;
          state_d = start_ok ? StPop : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state values so the registered copies line up with state_q.
  always_comb begin
    ser_d = 1'b1;
    case (state_d)
      StStart:  ser_d = 1'b0;
      StData:   ser_d = shift_d[0];
`ifdef FIFO_SER_PARITY_EN
      StParity: ser_d = parity_d;
`endif
      default:  ser_d = 1'b1;
    endcase
    rd_en_d = (state_d == StPop);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StStop) && (cnt_d == CntLast);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      ser_q    <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIFO_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ser_q    <= ser_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FIFO_SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en_o = rd_en_q;
  assign ser_out_o    = ser_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Randomised bench for fifo_serializer: behavioural FIFO, frame-position reference model and a
// per-cycle compare, plus hand-written frame pins.
module tb_fifo_serializer;

  localparam int DATA_W  = 4;
  localparam int CLK_DIV = 4;
`ifdef FIFO_SER_PARITY_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W + 2;
`endif
  localparam int FRAME_LAST = 2 + NBITS * CLK_DIV - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tx_en = 1'b0;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              ser_out;
  logic              busy;
  logic              frame_done;

  logic [DATA_W-1:0] mem [1024];
  int                wr_ptr = 0;
  int                rd_ptr = 0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  // Reference model: position within the current frame counted from the POP cycle, -1 when idle.
  int                m_pos = -1;
  int                m_rd = 0;
  logic [DATA_W-1:0] m_word = '0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  fifo_serializer #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tx_en_i     (tx_en),
    .fifo_data_i (fifo_data),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en),
    .ser_out_o   (ser_out),
    .busy_o      (busy),
    .frame_done_o(frame_done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= -1;
    end else if (m_pos >= 0 && m_pos < FRAME_LAST) begin
      m_pos <= m_pos + 1;
    end else if (tx_en && (wr_ptr != m_rd)) begin
      m_pos  <= 0;
      m_word <= mem[m_rd];
      m_rd   <= m_rd + 1;
    end else begin
      m_pos <= -1;
    end
  end

  // Expected {rd_en, ser_out, busy, frame_done} at frame position p.
  function automatic logic [3:0] exp_out(input int p, input logic [DATA_W-1:0] w);
    int k;
    logic b;
    logic [DATA_W-1:0] tmp;
    if (p < 0) return 4'b0100;
    if (p == 0) return 4'b1110;
    if (p == 1) return 4'b0110;
    k = (p - 2) / CLK_DIV;
    if (k == 0) begin
      b = 1'b0;
    end else if (k <= DATA_W) begin
      tmp = w >> (k - 1);
      b   = tmp[0];
`ifdef FIFO_SER_PARITY_EN
    end else if (k == DATA_W + 1) begin
      b = ^w;
`endif
    end else begin
      b = 1'b1;
    end
    return {1'b0, b, 1'b1, (p == FRAME_LAST)};
  endfunction

  always @(negedge clk) begin
    logic [3:0] act;
    logic [3:0] exp;
    act = {fifo_rd_en, ser_out, busy, frame_done};
    exp = exp_out(m_pos, m_word);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t pos=%0d rd/ser/busy/done got %b expected %b",
               $time, m_pos, act, exp);
    end
    if (fifo_rd_en) rd_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    if (wr_ptr < 1024) begin
      mem[wr_ptr] = w;
      wr_ptr++;
    end
  endtask

  task automatic wait_rd(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!fifo_rd_en && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(fifo_rd_en), 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_pos < 0 && (wr_ptr == m_rd || !tx_en)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  initial begin
    int r0;
    int d0;
    logic [7:0] pin_pat;
    logic [DATA_W-1:0] pin_word;
    logic [DATA_W-1:0] burst [16];

    burst = '{4'b0000, 4'b0011, 4'b0110, 4'b1000, 4'b0010, 4'b0100, 4'b1010, 4'b0111,
              4'b1011, 4'b0110, 4'b1000, 4'b0010, 4'b0100, 4'b1010, 4'b0111, 4'b1011};
`ifdef FIFO_SER_PARITY_EN
    pin_word = 4'b0111;
    pin_pat  = 8'b0110_1110;  // 0,1,1,1,0,1,1 sent from bit 0 upward
`else
    pin_word = 4'b0011;
    pin_pat  = 8'b0010_0110;  // 0,1,1,0,0,1 sent from bit 0 upward
`endif

    // Reset state
    cycles(3);
    check("reset_ser", int'(ser_out), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_rd", int'(fifo_rd_en), 0);
    check("reset_done", int'(frame_done), 0);
    rst_n = 1'b1;

    // Empty FIFO with transmit enabled
    tx_en = 1'b1;
    cycles(100);
    check("empty_rd_cnt", rd_cnt, 0);
    check("empty_busy", int'(busy), 0);
    check("empty_ser", int'(ser_out), 1);

    // Single pinned frame
    tx_en = 1'b0;
    cycles(1);
    push(pin_word);
    r0 = rd_cnt;
    d0 = done_cnt;
    tx_en = 1'b1;
    wait_rd("pin_rd");
    cycles(1);
    for (int i = 0; i < NBITS * CLK_DIV; i++) begin
      cycles(1);
      check("pin_ser", int'(ser_out), int'(pin_pat[i / CLK_DIV]));
      if (i == NBITS * CLK_DIV - 1) check("pin_done", int'(frame_done), 1);
    end
    cycles(3);
    check("pin_rd_count", rd_cnt - r0, 1);
    check("pin_done_count", done_cnt - d0, 1);
    check("pin_busy_after", int'(busy), 0);
    check("pin_ser_after", int'(ser_out), 1);

    // 16-word burst
    tx_en = 1'b0;
    cycles(1);
    foreach (burst[i]) push(burst[i]);
    r0 = rd_cnt;
    d0 = done_cnt;
    tx_en = 1'b1;
    wait_idle("burst_drain", 16 * (FRAME_LAST + 3) + 50);
    cycles(1);
    check("burst_rd_count", rd_cnt - r0, 16);
    check("burst_done_count", done_cnt - d0, 16);

    // tx_en dropped during DATA of a frame with words still queued
    tx_en = 1'b0;
    cycles(1);
    for (int i = 0; i < 4; i++) push(DATA_W'($urandom));
    r0 = rd_cnt;
    d0 = done_cnt;
    tx_en = 1'b1;
    wait_rd("drop_rd");
    cycles(2 + CLK_DIV + 2);
    tx_en = 1'b0;
    wait_idle("drop_idle", FRAME_LAST + 20);
    cycles(10);
    check("drop_rd_count", rd_cnt - r0, 1);
    check("drop_done_count", done_cnt - d0, 1);
    check("drop_busy", int'(busy), 0);

    // Asynchronous reset in the middle of DATA
    r0 = rd_cnt;
    tx_en = 1'b1;
    wait_rd("rst_rd");
    cycles(2 + CLK_DIV + 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ser", int'(ser_out), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_rd", int'(fifo_rd_en), 0);
    check("async_rst_done", int'(frame_done), 0);
    cycles(2);
    rst_n = 1'b1;
    wait_rd("rst_fresh_pop");
    cycles(1);
    check("rst_rd_count", rd_cnt - r0, 2);
    wait_idle("rst_drain", 4 * (FRAME_LAST + 3) + 50);
    check("rst_all_popped", rd_cnt, wr_ptr);

    // Randomised traffic with tx_en toggling
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(31, 0) == 0) push(DATA_W'($urandom));
      if ($urandom_range(39, 0) == 0) tx_en = ~tx_en;
    end
    tx_en = 1'b1;
    wait_idle("rand_drain", 300 * (FRAME_LAST + 3));
    cycles(2);
    check("rand_all_popped", rd_cnt, wr_ptr);
    check("rand_fifo_empty", int'(fifo_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
